// File: rtl/gemm_result_writer_if.sv
// Result-writer bus: the tile input from the GeMM controller / MAC array
// together with the output SRAM valid/ready write port.
interface gemm_result_writer_if #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32,
    parameter int M         = 4,
    parameter int N         = 4
) ();
    logic                       result_valid_i;
    logic [M*N*DataWidth-1:0]   result_data_i;
    logic [AddrWidth-1:0]       m_idx_i;
    logic [AddrWidth-1:0]       n_idx_i;

    logic                       sram_we_o;
    logic                       sram_ready_i;
    logic [AddrWidth-1:0]       sram_addr_o;
    logic [N*DataWidth-1:0]     sram_wdata_o;

    // The writer drives the SRAM request and consumes tiles.
    modport master (
        input  result_valid_i, result_data_i, m_idx_i, n_idx_i, sram_ready_i,
        output sram_we_o, sram_addr_o, sram_wdata_o
    );

    modport slave (
        output result_valid_i, result_data_i, m_idx_i, n_idx_i, sram_ready_i,
        input  sram_we_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/gemm_result_writer.sv
// Buffers finished M x N GeMM output tiles in a small FIFO and drains each
// tile to the output SRAM one row per accepted beat.
module gemm_result_writer #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32,
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 ctrl_done_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    gemm_result_writer_if.master bus
);

    localparam int PW   = $clog2(FifoDepth);
    localparam int RW   = (M > 1) ? $clog2(M) : 1;
    localparam int TW   = M * N * DataWidth;
    localparam int RowW = N * DataWidth;

    typedef enum logic {
        Idle,
        Write
    } state_t;

    state_t               state, state_next;
    logic [RW-1:0]        row, row_next;
    logic [PW:0]          wptr, rptr;
    logic                 done_pending;
    logic                 overflow;

    logic [TW-1:0]        mem_data [FifoDepth];
    logic [AddrWidth-1:0] mem_m    [FifoDepth];
    logic [AddrWidth-1:0] mem_n    [FifoDepth];

    logic                 empty, full, push, beat, last_row, pop, more, done_fire;
    logic [PW-1:0]        head;
    logic [TW-1:0]        head_tile;

    function automatic logic [AddrWidth-1:0] row_addr(
        input logic [AddrWidth-1:0] base,
        input logic [AddrWidth-1:0] nsize,
        input logic [AddrWidth-1:0] midx,
        input logic [AddrWidth-1:0] nidx,
        input logic [RW-1:0]        r
    );
        logic [AddrWidth-1:0] stride;
        logic [AddrWidth-1:0] row_idx;
        stride  = nsize / AddrWidth'(N);
        row_idx = midx * AddrWidth'(M) + AddrWidth'(r);
        return base + row_idx * stride + nidx;
    endfunction

    // The extra pointer bit separates full from empty when the low bits match.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign push     = bus.result_valid_i && !full;
    assign beat     = (state == Write) && bus.sram_ready_i;
    assign last_row = (row == RW'(M - 1));
    assign pop      = beat && last_row;
    assign more     = ((rptr + (PW+1)'(1)) != wptr) || push;
    assign head     = rptr[PW-1:0];
    assign head_tile = mem_data[head];

    assign done_fire = done_pending && empty && (state == Idle) && !push;

    always_comb begin
        state_next = state;
        row_next   = row;
        case (state)
            Idle: begin
                // Looking at push as well lets a fresh tile write one cycle later.
                if (!empty || push) begin
                    state_next = Write;
                    row_next   = '0;
                end
            end
            Write: begin
                if (beat) begin
                    if (last_row) begin
                        row_next   = '0;
                        state_next = more ? Write : Idle;
                    end else begin
                        row_next = row + RW'(1);
                    end
                end
            end
            default: begin
                state_next = Idle;
                row_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= Idle;
            row          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            done_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state <= state_next;
            row   <= row_next;
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop)  rptr <= rptr + (PW+1)'(1);
            if (start_i)          done_pending <= 1'b0;
            else if (ctrl_done_i) done_pending <= 1'b1;
            else if (done_fire)   done_pending <= 1'b0;
            overflow <= (overflow && !start_i) || (bus.result_valid_i && full);
        end
    end

    // Tile storage carries no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wptr[PW-1:0]] <= bus.result_data_i;
            mem_m[wptr[PW-1:0]]    <= bus.m_idx_i;
            mem_n[wptr[PW-1:0]]    <= bus.n_idx_i;
        end
    end

    assign bus.sram_we_o    = (state == Write);
    assign bus.sram_addr_o  = (state == Write)
                            ? row_addr(base_addr_i, N_size_i, mem_m[head], mem_n[head], row)
                            : '0;
    assign bus.sram_wdata_o = (state == Write) ? head_tile[row*RowW +: RowW] : '0;

    assign done_o     = done_fire;
    assign overflow_o = overflow;
    assign busy_o     = !empty || (state == Write) || (done_pending && !done_fire);

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench for gemm_result_writer: one task per scenario, inline checks.
module tb_gemm_result_writer;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TM = 4;
    localparam int TN = 4;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          ctrl_done;
    logic [AW-1:0] nsize;
    logic [AW-1:0] base;
    logic          busy;
    logic          done;
    logic          ovf;

    int vectors;
    int miscompares;

    gemm_result_writer_if #(.AddrWidth(AW), .DataWidth(DW), .M(TM), .N(TN)) bus ();

    gemm_result_writer #(
        .AddrWidth(AW), .DataWidth(DW), .M(TM), .N(TN), .FifoDepth(FD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .ctrl_done_i (ctrl_done),
        .N_size_i    (nsize),
        .base_addr_i (base),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (ovf),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element (r,c) of tile "seed" is seed*16 + r*4 + c.
    function automatic logic [TM*TN*DW-1:0] mk_tile(input int seed);
        logic [TM*TN*DW-1:0] t;
        t = '0;
        for (int r = 0; r < TM; r++)
            for (int c = 0; c < TN; c++)
                t[(r*TN+c)*DW +: DW] = DW'(seed*16 + r*4 + c);
        return t;
    endfunction

    function automatic logic [TN*DW-1:0] exp_row(input int seed, input int r);
        logic [TN*DW-1:0] v;
        for (int c = 0; c < TN; c++)
            v[c*DW +: DW] = DW'(seed*16 + r*4 + c);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tile(input int seed, input int m, input int n);
        bus.result_valid_i = 1'b1;
        bus.result_data_i  = mk_tile(seed);
        bus.m_idx_i        = AW'(m);
        bus.n_idx_i        = AW'(n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ctrl_done = 1'b0;
        nsize = AW'(8); base = AW'(16'h100);
        bus.result_valid_i = 1'b0; bus.result_data_i = '0;
        bus.m_idx_i = '0; bus.n_idx_i = '0; bus.sram_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.sram_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", bus.sram_we_o); end
        vectors++; if (bus.sram_addr_o !== '0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.sram_addr_o); end
        vectors++; if (bus.sram_wdata_o !== '0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", bus.sram_wdata_o); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        tick();
        vectors++; if ({bus.sram_we_o, busy, done} !== 3'b000) begin miscompares++; $display("FAIL post_reset_idle: got we/busy/done %b want 000", {bus.sram_we_o, busy, done}); end
    endtask

    task automatic test_single_tile();
        logic [AW-1:0]    addr_exp [4];
        logic [TN*DW-1:0] row0_exp;
        addr_exp = '{16'h109, 16'h10B, 16'h10D, 16'h10F};
        row0_exp = {32'd3, 32'd2, 32'd1, 32'd0};
        base = AW'(16'h100); nsize = AW'(8); bus.sram_ready_i = 1'b1;
        drive_tile(0, 1, 1);
        #1;
        vectors++; if (bus.sram_we_o !== 1'b0) begin miscompares++; $display("FAIL single_we_at_push: got %b want 0", bus.sram_we_o); end
        tick();
        bus.result_valid_i = 1'b0;
        #1;
        vectors++; if (bus.sram_wdata_o !== row0_exp) begin miscompares++; $display("FAIL single_row0_literal: got %h want %h", bus.sram_wdata_o, row0_exp); end
        for (int r = 0; r < TM; r++) begin
            vectors++; if (bus.sram_we_o !== 1'b1) begin miscompares++; $display("FAIL single_we row %0d: got %b want 1", r, bus.sram_we_o); end
            vectors++; if (bus.sram_addr_o !== addr_exp[r]) begin miscompares++; $display("FAIL single_addr row %0d: got %h want %h", r, bus.sram_addr_o, addr_exp[r]); end
            vectors++; if (bus.sram_wdata_o !== exp_row(0, r)) begin miscompares++; $display("FAIL single_wdata row %0d: got %h want %h", r, bus.sram_wdata_o, exp_row(0, r)); end
            tick();
        end
        vectors++; if ({bus.sram_we_o, busy} !== 2'b00) begin miscompares++; $display("FAIL single_idle_after: got we/busy %b want 00", {bus.sram_we_o, busy}); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] addr_exp [4];
        int acc;
        int stalls;
        addr_exp = '{16'h100, 16'h102, 16'h104, 16'h106};
        acc = 0; stalls = 0;
        base = AW'(16'h100); nsize = AW'(8); bus.sram_ready_i = 1'b1;
        drive_tile(1, 0, 0);
        tick();
        bus.result_valid_i = 1'b0;
        for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
            if (acc == 2 && stalls < 3) begin bus.sram_ready_i = 1'b0; stalls++; end
            else bus.sram_ready_i = 1'b1;
            #1;
            vectors++; if (bus.sram_we_o !== 1'b1) begin miscompares++; $display("FAIL bp_we cyc %0d: got %b want 1", cyc, bus.sram_we_o); end
            vectors++; if (bus.sram_addr_o !== addr_exp[acc]) begin miscompares++; $display("FAIL bp_addr cyc %0d: got %h want %h", cyc, bus.sram_addr_o, addr_exp[acc]); end
            vectors++; if (bus.sram_wdata_o !== exp_row(1, acc)) begin miscompares++; $display("FAIL bp_wdata cyc %0d: got %h want %h", cyc, bus.sram_wdata_o, exp_row(1, acc)); end
            if (bus.sram_ready_i) acc++;
            tick();
        end
        bus.sram_ready_i = 1'b1;
        #1;
        vectors++; if (acc !== 4) begin miscompares++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        vectors++; if (bus.sram_we_o !== 1'b0) begin miscompares++; $display("FAIL bp_extra_write: got we %b want 0", bus.sram_we_o); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addr_exp [12];
        int tm [3];
        int tn [3];
        addr_exp = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd1, 16'd3, 16'd5, 16'd7,
                     16'd8, 16'd10, 16'd12, 16'd14};
        tm = '{0, 0, 1};
        tn = '{0, 1, 0};
        base = '0; nsize = AW'(8); bus.sram_ready_i = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc < 3) drive_tile(2 + cyc, tm[cyc], tn[cyc]);
            else bus.result_valid_i = 1'b0;
            #1;
            if (cyc >= 1 && cyc <= 12) begin
                vectors++; if (bus.sram_we_o !== 1'b1) begin miscompares++; $display("FAIL b2b_we cyc %0d: got %b want 1", cyc, bus.sram_we_o); end
                vectors++; if (bus.sram_addr_o !== addr_exp[cyc-1]) begin miscompares++; $display("FAIL b2b_addr cyc %0d: got %h want %h", cyc, bus.sram_addr_o, addr_exp[cyc-1]); end
                vectors++; if (bus.sram_wdata_o !== exp_row(2 + (cyc-1)/4, (cyc-1)%4)) begin miscompares++; $display("FAIL b2b_wdata cyc %0d: got %h want %h", cyc, bus.sram_wdata_o, exp_row(2 + (cyc-1)/4, (cyc-1)%4)); end
            end else begin
                vectors++; if (bus.sram_we_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_we cyc %0d: got %b want 0", cyc, bus.sram_we_o); end
            end
            tick();
        end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_overflow: got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        int acc;
        logic [AW-1:0] a_exp;
        acc = 0;
        base = '0; nsize = AW'(32); bus.sram_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_tile(5 + k, 0, k);
            #1;
            if (k == 4) begin
                vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_before_fifth: got %b want 0", ovf); end
            end
            tick();
        end
        bus.result_valid_i = 1'b0;
        #1;
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_after_fifth: got %b want 1", ovf); end
        bus.sram_ready_i = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (bus.sram_we_o === 1'b1) begin
                a_exp = AW'((acc % 4) * 8 + acc / 4);
                vectors++; if (bus.sram_addr_o !== a_exp) begin miscompares++; $display("FAIL ovf_addr write %0d: got %h want %h", acc, bus.sram_addr_o, a_exp); end
                vectors++; if (bus.sram_wdata_o !== exp_row(5 + acc/4, acc % 4)) begin miscompares++; $display("FAIL ovf_wdata write %0d: got %h want %h", acc, bus.sram_wdata_o, exp_row(5 + acc/4, acc % 4)); end
                acc++;
            end
            tick();
        end
        vectors++; if (acc !== 16) begin miscompares++; $display("FAIL ovf_write_count: got %0d want 16", acc); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_start_clear: got %b want 0", ovf); end
    endtask

    task automatic test_done_ordering();
        int nwr;
        int last_wr;
        int ndone;
        int done_cyc;
        logic busy_at_done;
        logic busy_hist [20];
        nwr = 0; last_wr = -1; ndone = 0; done_cyc = -1; busy_at_done = 1'b1;
        base = '0; nsize = AW'(8); bus.sram_ready_i = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 2) drive_tile(10 + cyc, 0, cyc);
            else bus.result_valid_i = 1'b0;
            ctrl_done = (cyc == 1);
            #1;
            busy_hist[cyc] = busy;
            if (bus.sram_we_o === 1'b1) begin nwr++; last_wr = cyc; end
            if (done === 1'b1) begin ndone++; done_cyc = cyc; busy_at_done = busy; end
            tick();
        end
        ctrl_done = 1'b0;
        vectors++; if (nwr !== 8) begin miscompares++; $display("FAIL done_writes: got %0d want 8", nwr); end
        vectors++; if (last_wr !== 8) begin miscompares++; $display("FAIL done_last_write_cycle: got %0d want 8", last_wr); end
        vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL done_pulse_count: got %0d want 1", ndone); end
        vectors++; if (done_cyc !== 9) begin miscompares++; $display("FAIL done_cycle: got %0d want 9", done_cyc); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL done_busy_fall: got %b want 0", busy_at_done); end
        vectors++; if (busy_hist[8] !== 1'b1) begin miscompares++; $display("FAIL done_busy_before: got %b want 1", busy_hist[8]); end
    endtask

    task automatic test_reset_mid_write();
        base = '0; nsize = AW'(8); bus.sram_ready_i = 1'b1;
        drive_tile(12, 0, 0);
        tick();
        drive_tile(13, 0, 1);
        tick();
        bus.result_valid_i = 1'b0;
        #1;
        vectors++; if (bus.sram_addr_o !== AW'(2)) begin miscompares++; $display("FAIL rst_mid_row1_addr: got %h want 0002", bus.sram_addr_o); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.sram_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_we: got %b want 0", bus.sram_we_o); end
        vectors++; if (bus.sram_addr_o !== '0) begin miscompares++; $display("FAIL rst_mid_addr: got %h want 0", bus.sram_addr_o); end
        vectors++; if (bus.sram_wdata_o !== '0) begin miscompares++; $display("FAIL rst_mid_wdata: got %h want 0", bus.sram_wdata_o); end
        vectors++; if ({busy, done, ovf} !== 3'b000) begin miscompares++; $display("FAIL rst_mid_status: got busy/done/ovf %b want 000", {busy, done, ovf}); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            vectors++; if ({bus.sram_we_o, done} !== 2'b00) begin miscompares++; $display("FAIL rst_after cyc %0d: got we/done %b want 00", cyc, {bus.sram_we_o, done}); end
            tick();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_tile();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_done_ordering();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
